wb_rgb_pwm: RTL and testbench

Wishbone slave that generates the three PWM drive signals (`stat_r`, `stat_g`, `stat_b`) feeding the SB_RGBA_DRV status-LED primitive. It replaces the free-running blink counter in the top level with firmware-controlled colour, blink and breathe effects. It sits on the peripheral crossbar at selector `4'h2` (0x30020000), alongside the misc and USB-serial slaves.

---
 rtl/wb_rgb_pwm.sv | 128 ++++++++++++
 tb/tb_wb_rgb_pwm.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wb_rgb_pwm.sv
// wb_rgb_pwm: Wishbone-controlled RGB status LED PWM with off/static/blink/breathe effects
// Ports: wb_clk_i/wb_reset_i (async active-low) clock and reset; wb_* classic Wishbone slave
// (four 32-bit registers at wb_adr_i[1:0]); stat_r/g/b registered PWM drives for SB_RGBA_DRV.
module wb_rgb_pwm #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int CLK_FREQ = 16000000
) (
  input  logic          wb_clk_i,
  input  logic          wb_reset_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  output logic [DW-1:0] wb_dat_o,
  input  logic          wb_we_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic          wb_ack_o,
  output logic          stat_r,
  output logic          stat_g,
  output logic          stat_b
);
  localparam int DIV = CLK_FREQ / 1000;
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {M_OFF, M_STATIC, M_BLINK, M_BREATHE} mode_t;
  mode_t mode, new_mode;
  logic req, wr, mode_chg, tick, step;
  logic [23:0] color;
  logic [15:0] period, per_eff, step_cnt;
  logic [TW-1:0] tick_cnt;
  logic [7:0] scale, scale_n, pwm_cnt;
  logic dir, dir_n, phase, phase_n;
  logic [2:0] hit;
  logic [DW-1:0] rdata;
  logic unused;
  assign unused = ^{wb_adr_i[AW-1:2], wb_dat_i[DW-1:24]};
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr = req & wb_we_i;
  assign new_mode = mode_t'(wb_dat_i[1:0]);
  // Only a write that actually changes the mode restarts the effect.
  assign mode_chg = wr && (wb_adr_i[1:0] == 2'd0) && wb_sel_i[0] && (new_mode != mode);
  assign per_eff = (period == 16'd0) ? 16'd1 : period;
  assign tick = tick_cnt == TW'(DIV - 1);
  // >= lets a PERIOD shrunk below the running count clear on the next tick.
  assign step = tick && (({1'b0, step_cnt} + 17'd1) >= {1'b0, per_eff});
  assign {stat_b, stat_g, stat_r} = hit;
  always_comb begin
    rdata = (wb_adr_i[1:0] == 2'd0) ? {30'd0, mode} :
            (wb_adr_i[1:0] == 2'd1) ? {8'd0, color} :
            (wb_adr_i[1:0] == 2'd2) ? {16'd0, period} :
                                      {22'd0, phase, dir, scale};
  end
  always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
    if (!wb_reset_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      mode <= M_OFF;
      color <= 24'd0;
      period <= 16'd500;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rdata : '0;
      if (wr && wb_adr_i[1:0] == 2'd0 && wb_sel_i[0]) mode <= new_mode;
      for (int i = 0; i < 3; i++)
        if (wr && wb_adr_i[1:0] == 2'd1 && wb_sel_i[i]) color[8*i+:8] <= wb_dat_i[8*i+:8];
      for (int i = 0; i < 2; i++)
        if (wr && wb_adr_i[1:0] == 2'd2 && wb_sel_i[i]) period[8*i+:8] <= wb_dat_i[8*i+:8];
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
    if (!wb_reset_i) begin
      tick_cnt <= '0;
      step_cnt <= 16'd0;
    end else begin
      tick_cnt <= (mode_chg || tick) ? '0 : tick_cnt + 1'b1;
      step_cnt <= (mode_chg || step) ? 16'd0 : tick ? step_cnt + 16'd1 : step_cnt;
    end
  end
  // A mode change takes priority over a coincident step, which is dropped.
  always_comb begin
    scale_n = scale;
    dir_n = dir;
    phase_n = phase;
    if (mode_chg) begin
      scale_n = (new_mode == M_STATIC || new_mode == M_BLINK) ? 8'hFF : 8'h00;
      dir_n = 1'b0;
      phase_n = new_mode == M_BLINK;
    end else if (step && mode == M_BLINK) begin
      phase_n = ~phase;
      scale_n = phase ? 8'h00 : 8'hFF;
    end else if (step && mode == M_BREATHE) begin
      scale_n = dir ? scale - 8'd1 : scale + 8'd1;
      dir_n = dir ? (scale != 8'd1) : (scale == 8'd254);
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
    if (!wb_reset_i) begin
      scale <= 8'd0;
      dir <= 1'b0;
      phase <= 1'b0;
      pwm_cnt <= 8'd0;
    end else begin
      scale <= scale_n;
      dir <= dir_n;
      phase <= phase_n;
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [15:0] prod;
    logic [7:0] duty;
    logic on;
    logic unused_lo;
    // scale+1 makes full scale an exact pass-through of the colour byte.
    assign prod = {8'd0, color[8*c+:8]} * ({8'd0, scale} + 16'd1);
    assign unused_lo = ^prod[7:0];
    assign hit[c] = on;
    always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
      if (!wb_reset_i) begin
        duty <= 8'd0;
        on <= 1'b0;
      end else begin
        if (pwm_cnt == 8'hFF) duty <= prod[15:8];
        on <= pwm_cnt < duty;
      end
    end
  end
endmodule

// File: tb/tb_wb_rgb_pwm.sv
// tb_wb_rgb_pwm: directed self-checking bench for wb_rgb_pwm
module tb_wb_rgb_pwm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0] sel = 4'd0;
  logic [15:0] adr = 16'd0;
  logic [31:0] dati = 32'd0, dato;
  logic ack, sr, sg, sb;
  int n_assert = 0, n_fail = 0;
  int cur = 0;
  wb_rgb_pwm #(.AW(16), .DW(32), .CLK_FREQ(16000)) dut (
    .wb_clk_i(clk), .wb_reset_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dati), .wb_dat_o(dato),
    .wb_we_i(we), .wb_sel_i(sel), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack),
    .stat_r(sr), .stat_g(sg), .stat_b(sb)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] q);
    int n;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = {14'd0, a}; dati = d; sel = s;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    q = dato;
    cyc = 0; stb = 0; we = 0;
    chk("ack_latency", n, 1);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    xfer(1'b1, a, d, s, q);
  endtask
  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] q;
    xfer(1'b0, a, 32'd0, 4'hF, q);
    chk(tag, q, exp);
  endtask
  task automatic count_hi(input int n, output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    repeat (n) begin
      @(posedge clk); #1;
      r += int'(sr); g += int'(sg); b += int'(sb);
    end
  endtask
  // Read STATUS so that it reflects the state m steps after the last mode-change ack.
  task automatic status_at(input string tag, input int m, input logic [31:0] exp);
    int t;
    t = 2 + 16 * m;
    repeat (t - cur - 2) @(posedge clk);
    rd(tag, 2'd3, exp);
    cur = t;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int r, g, b, n, acks;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stat", {sr, sg, sb}, 3'b000);
    chk("rst_ack", ack, 0);
    chk("rst_dat", dato, 0);
    rst_n = 1;
    count_hi(2000, r, g, b);
    chk("idle_hi", r + g + b, 0);
    rd("rst_ctrl", 2'd0, 32'h0);
    rd("rst_color", 2'd1, 32'h0);
    rd("rst_period", 2'd2, 32'h1F4);
    rd("rst_status", 2'd3, 32'h0);
    @(posedge clk); #1;
    chk("dat_idle", dato, 0);
    // static colour
    wr(2'd1, 32'h00FF4000, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    rd("ctrl_static", 2'd0, 32'h1);
    rd("status_static", 2'd3, 32'h0FF);
    repeat (600) @(posedge clk);
    count_hi(256, r, g, b);
    chk("static_r", r, 0);
    chk("static_g", g, 64);
    chk("static_b", b, 255);
    // back-to-back strobes and strobe without cycle
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = 16'd0;
    acks = 0;
    repeat (4) begin @(posedge clk); #1; acks += int'(ack); end
    cyc = 0; stb = 0;
    chk("b2b_acks", acks, 2);
    stb = 1;
    acks = 0;
    repeat (4) begin @(posedge clk); #1; acks += int'(ack); end
    stb = 0;
    chk("nocyc_acks", acks, 0);
    // byte-lane write and frame-boundary update
    wr(2'd1, 32'h00112233, 4'hF);
    repeat (600) @(posedge clk);
    n = 0;
    while (dut.pwm_cnt != 8'd100 && n < 300) begin @(posedge clk); #1; n++; end
    chk("sync100", n < 300, 1);
    wr(2'd1, 32'h00008000, 4'b0010);
    g = 0; n = 0;
    while (dut.pwm_cnt != 8'd0 && n < 300) begin g += int'(sg); @(posedge clk); #1; n++; end
    chk("g_old_frame", g, 0);
    count_hi(256, r, g, b);
    chk("g_new_frame", g, 128);
    chk("r_frame", r, 51);
    chk("b_frame", b, 17);
    rd("color_sel", 2'd1, 32'h00118033);
    // blink, one step per 16 clocks
    wr(2'd2, 32'h1, 4'b0011);
    wr(2'd0, 32'h2, 4'h1);
    rd("blink0", 2'd3, 32'h2FF);
    repeat (14) @(posedge clk);
    rd("blink1", 2'd3, 32'h000);
    repeat (14) @(posedge clk);
    rd("blink2", 2'd3, 32'h2FF);
    repeat (14) @(posedge clk);
    rd("blink3", 2'd3, 32'h000);
    // breathe
    wr(2'd1, 32'h000000FF, 4'hF);
    wr(2'd0, 32'h3, 4'h1);
    cur = 0;
    status_at("br_0", 0, 32'h000);
    status_at("br_100", 100, 32'h064);
    status_at("br_255", 255, 32'h1FF);
    status_at("br_256", 256, 32'h1FE);
    status_at("br_510", 510, 32'h000);
    status_at("br_511", 511, 32'h001);
    status_at("br_611", 611, 32'h065);
    wr(2'd2, 32'h0000FFFF, 4'b0011);
    repeat (600) @(posedge clk);
    count_hi(256, r, g, b);
    chk("br_r_duty", r, 101);
    chk("br_gb_duty", g + b, 0);
    rd("br_frozen", 2'd3, 32'h065);
    // reset mid-strobe while breathing
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = 16'd1;
    #2 rst_n = 0;
    #1;
    chk("arst_stat", {sr, sg, sb}, 3'b000);
    chk("arst_ack", ack, 0);
    chk("arst_dat", dato, 0);
    @(posedge clk); #1;
    chk("arst_noack", ack, 0);
    cyc = 0; stb = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("post_ack", ack, 0);
    rd("post_ctrl", 2'd0, 32'h0);
    rd("post_color", 2'd1, 32'h0);
    rd("post_period", 2'd2, 32'h1F4);
    rd("post_status", 2'd3, 32'h0);
    count_hi(300, r, g, b);
    chk("post_hi", r + g + b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
